// File: rtl/exec_seq_if.sv
// Signal bundle around the instruction sequencer: fetch port, decoder class flags,
// store-byte and keyboard handshakes, and the strobes/values fed to the datapath.
interface exec_seq_if #(
  parameter int PC_W = 18
);
  logic            run;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [17:0]     imem_data;
  logic [17:0]     ir;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] link;
  logic            do_alu;
  logic            do_shift;
  logic            do_write;
  logic            do_stb;
  logic            do_readkbd;
  logic            do_jump;
  logic            cond_true;
  logic [PC_W-1:0] jump_target;
  logic            stb_req;
  logic            stb_ack;
  logic            kbd_valid;
  logic            kbd_pop;
  logic            rf_we;
  logic            flags_we;
  logic            busy;

  // Sequencer side.
  modport master (
    input  run, imem_ack, imem_data,
    input  do_alu, do_shift, do_write, do_stb, do_readkbd, do_jump,
    input  cond_true, jump_target, stb_ack, kbd_valid,
    output imem_req, imem_addr, ir, pc, link,
    output stb_req, kbd_pop, rf_we, flags_we, busy
  );

  // Memory / decoder / datapath side.
  modport slave (
    output run, imem_ack, imem_data,
    output do_alu, do_shift, do_write, do_stb, do_readkbd, do_jump,
    output cond_true, jump_target, stb_ack, kbd_valid,
    input  imem_req, imem_addr, ir, pc, link,
    input  stb_req, kbd_pop, rf_we, flags_we, busy
  );
endinterface

// File: rtl/exec_seq.sv
// Instruction sequencer: owns PC and IR, fetches over a req/ack port and sequences
// one execute step per instruction from the decoder's class flags.
module exec_seq #(
  parameter int              PC_W     = 18,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic       clk,
  input  logic       rst,
  exec_seq_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    STORE,
    KBD
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [17:0]     ir_q, ir_d;
  logic [PC_W-1:0] pc_inc;
  logic            take_jump;
  logic            commit;
  logic            kbd_take;
  logic            imem_req;
  logic            stb_req;
  logic            rf_we;
  logic            flags_we;

  assign pc_inc    = pc_q + PC_W'(1);
  assign take_jump = bus.do_jump & bus.cond_true;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    commit   = 1'b0;
    kbd_take = 1'b0;
    imem_req = 1'b0;
    stb_req  = 1'b0;
    rf_we    = 1'b0;
    flags_we = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.run) state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ack) begin
          ir_d    = bus.imem_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // A keyboard read whose byte is already waiting pops it and commits here.
        if (bus.do_stb) begin
          state_d = STORE;
        end else if (bus.do_readkbd && !bus.kbd_valid) begin
          state_d = KBD;
        end else begin
          commit   = 1'b1;
          kbd_take = bus.do_readkbd;
        end
      end
      STORE: begin
        stb_req = 1'b1;
        if (bus.stb_ack) commit = 1'b1;
      end
      KBD: begin
        if (bus.kbd_valid) begin
          commit   = 1'b1;
          kbd_take = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Shift ops never touch the flags, even if a decoder ever raised do_alu with them.
    if (commit) begin
      rf_we    = bus.do_write | kbd_take;
      flags_we = bus.do_alu & ~bus.do_shift;
      pc_d     = take_jump ? bus.jump_target : pc_inc;
      state_d  = bus.run ? FETCH : IDLE;
    end
  end

  assign bus.imem_req  = imem_req;
  assign bus.imem_addr = pc_q;
  assign bus.pc        = pc_q;
  assign bus.link      = pc_inc;
  assign bus.ir        = ir_q;
  assign bus.stb_req   = stb_req;
  assign bus.kbd_pop   = kbd_take;
  assign bus.rf_we     = rf_we;
  assign bus.flags_we  = flags_we;
  assign bus.busy      = (state_q != IDLE);

  // The two memory-side requests never overlap, and a pending fetch holds its address.
  a_req_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(imem_req && stb_req));

  a_fetch_stable: assert property (@(posedge clk) disable iff (rst)
    (imem_req && !bus.imem_ack) |=> (imem_req && $stable(pc_q)));

endmodule

// File: tb/tb_exec_seq.sv
// Randomised bench for exec_seq: an instruction-level model drives every cycle and
// records the outputs the sequencer must show; one negedge process compares them.
module tb_exec_seq;
  localparam int PC_W = 18;

  logic clk;
  logic rst;

  exec_seq_if #(.PC_W(PC_W)) bus ();

  exec_seq #(.PC_W(PC_W), .RESET_PC(18'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  bit          checkEn = 1'b0;
  logic        expReq, expStb, expPop, expRf, expFlags, expBusy;
  logic [17:0] expAddr, expPc, expLink, expIr;
  logic [17:0] mPc, mIr;
  bit          pinEn = 1'b0;
  string       pinName;
  logic [31:0] pinAct, pinExp;
  int          stbCnt = 0;
  int          popCnt = 0;
  int          popRfCnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("imem_req",  32'(bus.imem_req),  32'(expReq));
      checkOutput("imem_addr", 32'(bus.imem_addr), 32'(expAddr));
      checkOutput("pc",        32'(bus.pc),        32'(expPc));
      checkOutput("link",      32'(bus.link),      32'(expLink));
      checkOutput("ir",        32'(bus.ir),        32'(expIr));
      checkOutput("stb_req",   32'(bus.stb_req),   32'(expStb));
      checkOutput("kbd_pop",   32'(bus.kbd_pop),   32'(expPop));
      checkOutput("rf_we",     32'(bus.rf_we),     32'(expRf));
      checkOutput("flags_we",  32'(bus.flags_we),  32'(expFlags));
      checkOutput("busy",      32'(bus.busy),      32'(expBusy));
    end
    if (pinEn) checkOutput(pinName, pinAct, pinExp);
    if (bus.stb_req === 1'b1) stbCnt++;
    if (bus.kbd_pop === 1'b1) popCnt++;
    if (bus.kbd_pop === 1'b1 && bus.rf_we === 1'b1) popRfCnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    pinEn = 1'b0;
  endtask

  task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
    pinName = name;
    pinAct  = act;
    pinExp  = exp;
    pinEn   = 1'b1;
  endtask

  task automatic expectQuiet(input logic busyV);
    expReq   = 1'b0;
    expStb   = 1'b0;
    expPop   = 1'b0;
    expRf    = 1'b0;
    expFlags = 1'b0;
    expBusy  = busyV;
    expPc    = mPc;
    expAddr  = mPc;
    expLink  = mPc + 18'd1;
    expIr    = mIr;
  endtask

  // Inputs whose value must not matter outside the state that waits on them.
  task automatic junkBus();
    bus.imem_ack  = 1'($urandom_range(0, 1));
    bus.imem_data = 18'($urandom);
    bus.stb_ack   = 1'($urandom_range(0, 1));
    bus.kbd_valid = 1'($urandom_range(0, 1));
  endtask

  task automatic junkDecoder();
    bus.do_alu      = 1'($urandom_range(0, 1));
    bus.do_shift    = 1'($urandom_range(0, 1));
    bus.do_write    = 1'($urandom_range(0, 1));
    bus.do_stb      = 1'($urandom_range(0, 1));
    bus.do_readkbd  = 1'($urandom_range(0, 1));
    bus.do_jump     = 1'($urandom_range(0, 1));
    bus.cond_true   = 1'($urandom_range(0, 1));
    bus.jump_target = 18'($urandom);
  endtask

  task automatic commitCycle(input logic pop, input logic runAfter);
    logic [17:0] nextPc;
    nextPc   = (bus.do_jump && bus.cond_true) ? bus.jump_target : mPc + 18'd1;
    bus.run  = runAfter;
    expRf    = bus.do_write | pop;
    expFlags = bus.do_alu;
    expPop   = pop;
    tick();
    mPc = nextPc;
  endtask

  task automatic idleThenStart(input int n);
    for (int i = 0; i < n; i++) begin
      junkBus();
      junkDecoder();
      bus.run = 1'b0;
      expectQuiet(1'b0);
      tick();
    end
    junkBus();
    junkDecoder();
    bus.run = 1'b1;
    expectQuiet(1'b0);
    tick();
  endtask

  // One stalled fetch cycle whose address is checked against a hand-computed value.
  task automatic peekFetch(input logic [17:0] lit);
    junkBus();
    junkDecoder();
    bus.imem_ack = 1'b0;
    bus.run      = 1'($urandom_range(0, 1));
    expectQuiet(1'b1);
    expReq  = 1'b1;
    expAddr = lit;
    expPc   = lit;
    expLink = lit + 18'd1;
    pin("fetch_pc_model", 32'(mPc), 32'(lit));
    tick();
  endtask

  // Runs one instruction starting in a fetch cycle; leaves the sequencer fetching again.
  task automatic applyStimulus(input logic [17:0] word, input int ackDly,
      input logic alu, input logic shift, input logic wr, input logic stb,
      input logic rdk, input logic jmp, input logic cond, input logic [17:0] target,
      input int hsDly, input logic runAfter);
    for (int i = 0; i <= ackDly; i++) begin
      junkBus();
      junkDecoder();
      bus.run      = 1'($urandom_range(0, 1));
      bus.imem_ack = (i == ackDly);
      if (i == ackDly) bus.imem_data = word;
      expectQuiet(1'b1);
      expReq = 1'b1;
      tick();
    end
    mIr = word;
    junkBus();
    bus.do_alu      = alu;
    bus.do_shift    = shift;
    bus.do_write    = wr;
    bus.do_stb      = stb;
    bus.do_readkbd  = rdk;
    bus.do_jump     = jmp;
    bus.cond_true   = cond;
    bus.jump_target = target;
    bus.run         = 1'($urandom_range(0, 1));
    expectQuiet(1'b1);
    if (stb) begin
      tick();
      for (int i = 0; i <= hsDly; i++) begin
        junkBus();
        bus.stb_ack = (i == hsDly);
        bus.run     = 1'($urandom_range(0, 1));
        expectQuiet(1'b1);
        expStb = 1'b1;
        if (i == hsDly) commitCycle(1'b0, runAfter);
        else tick();
      end
    end else if (rdk && hsDly > 0) begin
      bus.kbd_valid = 1'b0;
      tick();
      for (int i = 1; i <= hsDly; i++) begin
        junkBus();
        bus.kbd_valid = (i == hsDly);
        bus.run       = 1'($urandom_range(0, 1));
        expectQuiet(1'b1);
        if (i == hsDly) commitCycle(1'b1, runAfter);
        else tick();
      end
    end else begin
      if (rdk) bus.kbd_valid = 1'b1;
      commitCycle(rdk, runAfter);
    end
    if (!runAfter) idleThenStart(int'($urandom_range(0, 2)));
  endtask

  task automatic randomInstr();
    int          kind;
    int          hs;
    logic        alu, shift, wr, stb, rdk, jmp, cond, runAfter;
    logic [17:0] target;
    kind = int'($urandom_range(0, 9));
    hs = 0;
    alu = 1'b0; shift = 1'b0; wr = 1'b0; stb = 1'b0;
    rdk = 1'b0; jmp = 1'b0; cond = 1'b0;
    target = 18'($urandom);
    runAfter = ($urandom_range(0, 3) != 0);
    case (kind)
      0, 1: begin stb = 1'b1; hs = int'($urandom_range(0, 4)); end
      2, 3: begin rdk = 1'b1; wr = 1'b1; hs = int'($urandom_range(0, 4)); end
      4, 5: begin
        jmp  = 1'b1;
        cond = 1'($urandom_range(0, 1));
        wr   = 1'($urandom_range(0, 1));
      end
      6: begin end
      7: begin shift = 1'b1; wr = 1'b1; end
      default: begin alu = 1'b1; wr = 1'($urandom_range(0, 1)); end
    endcase
    applyStimulus(18'($urandom), int'($urandom_range(0, 3)), alu, shift, wr, stb,
                  rdk, jmp, cond, target, hs, runAfter);
  endtask

  // Reset cycle carries both acks; neither may leave a trace.
  task automatic doReset();
    checkEn = 1'b0;
    rst = 1'b1;
    junkBus();
    bus.imem_ack = 1'b1;
    bus.stb_ack  = 1'b1;
    tick();
    rst = 1'b0;
    mPc = 18'h0;
    mIr = 18'h0;
    checkEn = 1'b1;
    junkBus();
    junkDecoder();
    bus.run = 1'b0;
    expectQuiet(1'b0);
    expPc   = 18'h0;
    expAddr = 18'h0;
    expLink = 18'h1;
    expIr   = 18'h0;
    tick();
  endtask

  task automatic resetInStore();
    junkBus();
    junkDecoder();
    bus.imem_ack  = 1'b1;
    bus.imem_data = 18'h0ABCD;
    bus.run       = 1'b1;
    expectQuiet(1'b1);
    expReq = 1'b1;
    tick();
    mIr = 18'h0ABCD;
    junkBus();
    junkDecoder();
    bus.do_stb = 1'b1;
    bus.do_readkbd = 1'b0;
    expectQuiet(1'b1);
    tick();
    junkBus();
    bus.stb_ack = 1'b0;
    expectQuiet(1'b1);
    expStb = 1'b1;
    tick();
    doReset();
  endtask

  initial begin
    int stbBase, popBase, bothBase;
    rst = 1'b1;
    bus.run = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_data = '0;
    bus.stb_ack = 1'b0;
    bus.kbd_valid = 1'b0;
    bus.do_alu = 1'b0; bus.do_shift = 1'b0; bus.do_write = 1'b0;
    bus.do_stb = 1'b0; bus.do_readkbd = 1'b0; bus.do_jump = 1'b0;
    bus.cond_true = 1'b0;
    bus.jump_target = '0;
    mPc = '0;
    mIr = '0;

    doReset();
    idleThenStart(1);

    repeat (3) applyStimulus(18'h00123, 0, 1, 0, 1, 0, 0, 0, 0, 18'h0, 0, 1);
    pin("alu_pc_model", 32'(mPc), 32'h3);
    repeat (2) applyStimulus(18'h3FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 18'h0, 0, 1);
    pin("nop_pc_model", 32'(mPc), 32'h5);

    applyStimulus(18'h20000, 1, 0, 0, 0, 0, 0, 1, 1, 18'h40, 0, 1);
    peekFetch(18'h40);
    applyStimulus(18'h20000, 0, 0, 0, 0, 0, 0, 1, 1, 18'h5, 0, 1);
    peekFetch(18'h5);
    applyStimulus(18'h20000, 0, 0, 0, 0, 0, 0, 1, 0, 18'h40, 0, 1);
    peekFetch(18'h6);

    applyStimulus(18'h20000, 0, 0, 0, 0, 0, 0, 1, 1, 18'h10, 0, 1);
    peekFetch(18'h10);
    applyStimulus(18'h21000, 0, 0, 0, 1, 0, 0, 1, 1, 18'h80, 0, 1);
    peekFetch(18'h80);

    stbBase = stbCnt;
    applyStimulus(18'h30000, 0, 0, 0, 0, 1, 0, 0, 0, 18'h0, 3, 1);
    peekFetch(18'h81);
    pin("stb_req_cycles", 32'(stbCnt - stbBase), 32'd4);

    popBase = popCnt;
    bothBase = popRfCnt;
    applyStimulus(18'h31000, 2, 0, 0, 1, 0, 1, 0, 0, 18'h0, 5, 1);
    peekFetch(18'h82);
    pin("kbd_pop_rf_pulses", 32'(((popCnt - popBase) << 8) | (popRfCnt - bothBase)), 32'h101);

    applyStimulus(18'h20000, 0, 0, 0, 0, 0, 0, 1, 1, 18'h3FFFF, 0, 1);
    peekFetch(18'h3FFFF);
    applyStimulus(18'h00123, 0, 1, 0, 1, 0, 0, 0, 0, 18'h0, 0, 1);
    peekFetch(18'h0);

    applyStimulus(18'h3FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 18'h0, 0, 0);
    peekFetch(18'h1);

    repeat (250) randomInstr();

    resetInStore();
    idleThenStart(0);
    randomInstr();
    doReset();
    idleThenStart(0);
    repeat (5) randomInstr();

    checkEn = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
